pe_mac_pipe: RTL and testbench

// - Parametrised, stallable multiply-accumulate PE for the compute PE array; next generation of the array's PE.
// - Each beat multiplies N_OPS ifmap/weight pairs, reduces them through a registered adder tree and accumulates

---
 rtl/pe_mac_pipe.sv | 239 +++++++++++++++++++++++
 tb/tb_pe_mac_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_pipe.sv
// Stallable N_OPS-lane multiply-accumulate PE: multiply, registered adder tree, accumulate, one result per channel.
// Optional output ReLU is enabled by defining PE_MAC_RELU_EN.
`timescale 1ns/1ps
module pe_mac_pipe #(
  parameter int N_OPS     = 8,
  parameter int DW        = 8,
  parameter int SIGNED    = 1,
  parameter int ACC_GUARD = 8,
  parameter int OCH_W     = 4,
  localparam int TREE_W   = 2*DW + $clog2(N_OPS),
  localparam int ACC_W    = TREE_W + ACC_GUARD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_OPS*DW-1:0]   ifmap,
  input  logic [N_OPS*DW-1:0]   weight,
  input  logic                  in_ch_start,
  input  logic                  in_ch_end,
  input  logic [OCH_W-1:0]      out_ch_in,
  input  logic                  psum_en,
  input  logic [ACC_W-1:0]      psum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      ofmap,
  output logic [OCH_W-1:0]      out_ch,
  output logic                  frame_err
);

  localparam logic SGN = (SIGNED != 0);
  localparam int   PW  = 2*DW;
  localparam int   TX  = TREE_W - PW;

  logic adv;
  logic accept;

  // S1 state
  logic              s1_valid_q, s1_valid_d;
  logic              s1_start_q, s1_start_d;
  logic              s1_end_q, s1_end_d;
  logic [OCH_W-1:0]  s1_och_q, s1_och_d;
  logic              s1_psum_en_q, s1_psum_en_d;
  logic [ACC_W-1:0]  s1_psum_q, s1_psum_d;
  logic [PW-1:0]     s1_prod_q [N_OPS];
  logic [PW-1:0]     s1_prod_d [N_OPS];

  // S2 state
  logic              s2_valid_q, s2_valid_d;
  logic              s2_start_q, s2_start_d;
  logic              s2_end_q, s2_end_d;
  logic [OCH_W-1:0]  s2_och_q, s2_och_d;
  logic              s2_psum_en_q, s2_psum_en_d;
  logic [ACC_W-1:0]  s2_psum_q, s2_psum_d;
  logic [TREE_W-1:0] s2_tree_q, s2_tree_d;

  // S3 / output state
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ch_open_q, ch_open_d;
  logic [OCH_W-1:0]  ch_idx_q, ch_idx_d;
  logic              frame_err_q, frame_err_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  ofmap_q, ofmap_d;
  logic [OCH_W-1:0]  out_ch_q, out_ch_d;

  logic [PW-1:0]     prod     [N_OPS];
  logic [TREE_W-1:0] prod_ext [N_OPS];
  logic [TREE_W-1:0] tree_lvl [N_OPS];
  logic [TREE_W-1:0] tree_sum;

  logic [ACC_W-1:0]  tree_ext;
  logic [ACC_W-1:0]  psum_add;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]  ofmap_new;
  logic              beat3;
  logic              err_now;

  // The whole pipe freezes only while a finished result waits for OMEM.
  assign adv      = !(out_valid_q && !out_ready);
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // Operands are extended to 2*DW so the low 2*DW product bits are exact in both sign modes.
  generate
    for (genvar gi = 0; gi < N_OPS; gi++) begin : g_lane
      logic [DW-1:0] a_l;
      logic [DW-1:0] w_l;
      assign a_l = ifmap[gi*DW +: DW];
      assign w_l = weight[gi*DW +: DW];
      assign prod[gi] = {{DW{SGN & a_l[DW-1]}}, a_l} * {{DW{SGN & w_l[DW-1]}}, w_l};
      assign prod_ext[gi] = {{TX{SGN & s1_prod_q[gi][PW-1]}}, s1_prod_q[gi]};
    end
  endgenerate

  always_comb begin : s1_next
    s1_valid_d   = s1_valid_q;
    s1_start_d   = s1_start_q;
    s1_end_d     = s1_end_q;
    s1_och_d     = s1_och_q;
    s1_psum_en_d = s1_psum_en_q;
    s1_psum_d    = s1_psum_q;
    for (int i = 0; i < N_OPS; i++) s1_prod_d[i] = s1_prod_q[i];
    if (adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_start_d   = in_ch_start;
        s1_end_d     = in_ch_end;
        s1_och_d     = out_ch_in;
        s1_psum_en_d = psum_en;
        s1_psum_d    = psum;
        for (int i = 0; i < N_OPS; i++) s1_prod_d[i] = prod[i];
      end
    end
  end

  // Pairwise reduction in place: each pass halves the live entries, log2(N_OPS) adder levels.
  always_comb begin : adder_tree
    for (int i = 0; i < N_OPS; i++) tree_lvl[i] = prod_ext[i];
    for (int s = N_OPS/2; s >= 1; s = s/2) begin
      for (int i = 0; i < s; i++) tree_lvl[i] = tree_lvl[2*i] + tree_lvl[2*i+1];
    end
    tree_sum = tree_lvl[0];
  end

  always_comb begin : s2_next
    s2_valid_d   = s2_valid_q;
    s2_start_d   = s2_start_q;
    s2_end_d     = s2_end_q;
    s2_och_d     = s2_och_q;
    s2_psum_en_d = s2_psum_en_q;
    s2_psum_d    = s2_psum_q;
    s2_tree_d    = s2_tree_q;
    if (adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_start_d   = s1_start_q;
        s2_end_d     = s1_end_q;
        s2_och_d     = s1_och_q;
        s2_psum_en_d = s1_psum_en_q;
        s2_psum_d    = s1_psum_q;
        s2_tree_d    = tree_sum;
      end
    end
  end

  always_comb begin : s3_next
    beat3    = adv && s2_valid_q;
    tree_ext = {{ACC_GUARD{SGN & s2_tree_q[TREE_W-1]}}, s2_tree_q};
    psum_add = (s2_end_q && s2_psum_en_q) ? s2_psum_q : '0;
    acc_base = s2_start_q ? '0 : acc_q;
    acc_next = acc_base + tree_ext + psum_add;
`ifdef PE_MAC_RELU_EN
    ofmap_new = (SGN && acc_next[ACC_W-1]) ? '0 : acc_next;
`else
    ofmap_new = acc_next;
`endif

    // A start must find no open channel; a continuation must find one with the same index.
    if (s2_start_q) err_now = ch_open_q;
    else            err_now = !ch_open_q || (s2_och_q != ch_idx_q);

    acc_d       = acc_q;
    ch_open_d   = ch_open_q;
    ch_idx_d    = ch_idx_q;
    frame_err_d = frame_err_q;
    if (beat3) begin
      acc_d       = acc_next;
      ch_open_d   = !s2_end_q && (s2_start_q || ch_open_q);
      frame_err_d = frame_err_q | err_now;
      if (s2_start_q) ch_idx_d = s2_och_q;
    end

    out_valid_d = out_valid_q;
    ofmap_d     = ofmap_q;
    out_ch_d    = out_ch_q;
    if (beat3 && s2_end_q) begin
      out_valid_d = 1'b1;
      ofmap_d     = ofmap_new;
      out_ch_d    = s2_och_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_start_q   <= 1'b0;
      s1_end_q     <= 1'b0;
      s1_och_q     <= '0;
      s1_psum_en_q <= 1'b0;
      s1_psum_q    <= '0;
      for (int i = 0; i < N_OPS; i++) s1_prod_q[i] <= '0;
      s2_valid_q   <= 1'b0;
      s2_start_q   <= 1'b0;
      s2_end_q     <= 1'b0;
      s2_och_q     <= '0;
      s2_psum_en_q <= 1'b0;
      s2_psum_q    <= '0;
      s2_tree_q    <= '0;
      acc_q        <= '0;
      ch_open_q    <= 1'b0;
      ch_idx_q     <= '0;
      frame_err_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      ofmap_q      <= '0;
      out_ch_q     <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_start_q   <= s1_start_d;
      s1_end_q     <= s1_end_d;
      s1_och_q     <= s1_och_d;
      s1_psum_en_q <= s1_psum_en_d;
      s1_psum_q    <= s1_psum_d;
      for (int i = 0; i < N_OPS; i++) s1_prod_q[i] <= s1_prod_d[i];
      s2_valid_q   <= s2_valid_d;
      s2_start_q   <= s2_start_d;
      s2_end_q     <= s2_end_d;
      s2_och_q     <= s2_och_d;
      s2_psum_en_q <= s2_psum_en_d;
      s2_psum_q    <= s2_psum_d;
      s2_tree_q    <= s2_tree_d;
      acc_q        <= acc_d;
      ch_open_q    <= ch_open_d;
      ch_idx_q     <= ch_idx_d;
      frame_err_q  <= frame_err_d;
      out_valid_q  <= out_valid_d;
      ofmap_q      <= ofmap_d;
      out_ch_q     <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ofmap     = ofmap_q;
  assign out_ch    = out_ch_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Scoreboard bench for pe_mac_pipe: beats drive a reference accumulator, results are compared in order at the output.
`timescale 1ns/1ps
module tb_pe_mac_pipe;
  localparam int N_OPS = 8;
  localparam int DW = 8;
  localparam int ACC_GUARD = 8;
  localparam int OCH_W = 4;
  localparam int TREE_W = 2*DW + $clog2(N_OPS);
  localparam int ACC_W = TREE_W + ACC_GUARD;

  logic clk, rst_n, in_valid, in_ready, in_ch_start, in_ch_end, psum_en, out_valid, out_ready, frame_err;
  logic [N_OPS*DW-1:0] ifmap, weight;
  logic [OCH_W-1:0] out_ch_in, out_ch;
  logic [ACC_W-1:0] psum, ofmap;

  pe_mac_pipe #(.N_OPS(N_OPS), .DW(DW), .SIGNED(1), .ACC_GUARD(ACC_GUARD), .OCH_W(OCH_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ifmap(ifmap), .weight(weight), .in_ch_start(in_ch_start), .in_ch_end(in_ch_end),
    .out_ch_in(out_ch_in), .psum_en(psum_en), .psum(psum), .out_valid(out_valid),
    .out_ready(out_ready), .ofmap(ofmap), .out_ch(out_ch), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ACC_W-1:0] val;
    logic [OCH_W-1:0] ch;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0] m_acc = '0;
  logic hold_flag = 1'b0;
  logic [ACC_W-1:0] hold_val;
  logic [OCH_W-1:0] hold_ch;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ACC_W-1:0] relu(input logic [ACC_W-1:0] v);
`ifdef PE_MAC_RELU_EN
    return v[ACC_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [N_OPS*DW-1:0] fill(input int v);
    logic [N_OPS*DW-1:0] r;
    for (int i = 0; i < N_OPS; i++) r[i*DW +: DW] = v[DW-1:0];
    return r;
  endfunction

  // Output monitor: one line per delivered result, in-order scoreboard compare, hold check while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_flag <= 1'b0;
    end else begin
      if (hold_flag && out_valid) begin
        check("hold_ofmap", 64'(ofmap), 64'(hold_val));
        check("hold_och", 64'(out_ch), 64'(hold_ch));
      end
      if (out_valid && out_ready) begin
        $display("RESULT ch=%0d ofmap=0x%0h", out_ch, ofmap);
        if (sb_q.size() == 0) begin
          check("sb_unexpected", 64'(1), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check("ofmap", 64'(ofmap), 64'(e.val));
          check("out_ch", 64'(out_ch), 64'(e.ch));
        end
      end
      hold_flag <= out_valid && !out_ready;
      hold_val  <= ofmap;
      hold_ch   <= out_ch;
    end
  end

  task automatic beat(input logic [N_OPS*DW-1:0] a, input logic [N_OPS*DW-1:0] w,
                      input logic st, input logic en, input logic [OCH_W-1:0] ch,
                      input logic pe, input logic [ACC_W-1:0] ps);
    bit done;
    int p;
    logic signed [DW-1:0] la, lw;
    logic [ACC_W-1:0] tsum;
    exp_t e;
    ifmap = a; weight = w; in_ch_start = st; in_ch_end = en;
    out_ch_in = ch; psum_en = pe; psum = ps; in_valid = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      check("in_ready_timeout", 64'(0), 64'(1));
    end else begin
      tsum = '0;
      for (int i = 0; i < N_OPS; i++) begin
        la = a[i*DW +: DW];
        lw = w[i*DW +: DW];
        p = int'(la) * int'(lw);
        tsum = tsum + ACC_W'(p);
      end
      if (st) m_acc = '0;
      m_acc = m_acc + tsum;
      if (en) begin
        if (pe) m_acc = m_acc + ps;
        e.val = relu(m_acc);
        e.ch = ch;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (sb_q.size() == 0 && !out_valid) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!done) check("drain_timeout", 64'(sb_q.size()), 64'(0));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_OPS*DW-1:0] a, w;
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ifmap = '0; weight = '0;
    in_ch_start = 1'b0; in_ch_end = 1'b0; out_ch_in = '0; psum_en = 1'b0; psum = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_ofmap", 64'(ofmap), 64'(0));
    check("rst_out_ch", 64'(out_ch), 64'(0));
    check("rst_frame_err", 64'(frame_err), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // single-beat channel, 8 lanes of 3*-2 -> -48, with latency check
    beat(fill(3), fill(-2), 1'b1, 1'b1, 4'd9, 1'b0, '0);
    check("t1_lat0", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check("t1_lat1", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check("t1_lat2", 64'(out_valid), 64'(1));
    drain();

    // 4-beat channel of 1*1 lanes, psum 100 on the end beat only -> 132
    for (int k = 0; k < 4; k++) begin
      beat(fill(1), fill(1), k == 0, k == 3, 4'd3, 1'b1, (k == 3) ? ACC_W'(100) : ACC_W'(55));
      if (k < 3) check("t2_no_out", 64'(out_valid), 64'(0));
    end
    drain();

    // backpressure: three single-beat channels giving 1,2,3 while out_ready is low for 5 cycles
    out_ready = 1'b0;
    seen = 1'b0;
    fork
      begin
        for (int k = 1; k <= 3; k++) begin
          a = '0; w = '0;
          a[DW-1:0] = 8'd1;
          w[DW-1:0] = 8'(k);
          beat(a, w, 1'b1, 1'b1, OCH_W'(k), 1'b0, '0);
        end
      end
      begin
        for (int c = 0; c < 5; c++) begin
          @(posedge clk); #2;
          if (out_valid && !seen) begin
            seen = 1'b1;
            check("t3_in_ready_low", 64'(in_ready), 64'(0));
          end
        end
        check("t3_stall_seen", 64'(seen), 64'(1));
        out_ready = 1'b1;
      end
    join
    drain();

    // random multi-beat channels with occasional bubbles
    for (int n = 0; n < 6; n++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        a = {$urandom, $urandom};
        w = {$urandom, $urandom};
        beat(a, w, k == 0, k == len-1, OCH_W'(n + 4), 1'($urandom), ACC_W'($urandom));
        if ($urandom_range(0, 1) == 1) idle(1);
      end
    end
    drain();
    check("frame_err_clean", 64'(frame_err), 64'(0));

    // -48 then +48 (ReLU clamps the negative one when enabled)
    beat(fill(3), fill(-2), 1'b1, 1'b1, 4'd1, 1'b0, '0);
    beat(fill(3), fill(2), 1'b1, 1'b1, 4'd2, 1'b0, '0);
    drain();

    // framing: channel-index mismatch inside an open channel, then a non-start beat after an end
    beat(fill(1), fill(1), 1'b1, 1'b0, 4'd1, 1'b0, '0);
    idle(3);
    check("t5_pre", 64'(frame_err), 64'(0));
    beat(fill(1), fill(1), 1'b0, 1'b0, 4'd2, 1'b0, '0);
    idle(3);
    check("t5_och_mismatch", 64'(frame_err), 64'(1));
    beat(fill(2), fill(1), 1'b0, 1'b1, 4'd1, 1'b0, '0);
    beat(fill(1), fill(3), 1'b0, 1'b1, 4'd1, 1'b0, '0);
    drain();
    check("t5_sticky", 64'(frame_err), 64'(1));
    beat(fill(1), fill(1), 1'b1, 1'b1, 4'd4, 1'b0, '0);
    drain();
    check("t5_sticky2", 64'(frame_err), 64'(1));

    // reset mid-channel with a result held at the output
    out_ready = 1'b0;
    beat(fill(2), fill(2), 1'b1, 1'b1, 4'd5, 1'b0, '0);
    beat(fill(1), fill(1), 1'b1, 1'b0, 4'd6, 1'b0, '0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (out_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("t6_held", 64'(seen), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_out_valid", 64'(out_valid), 64'(0));
    check("t6_ofmap", 64'(ofmap), 64'(0));
    check("t6_out_ch", 64'(out_ch), 64'(0));
    check("t6_frame_err", 64'(frame_err), 64'(0));
    sb_q.delete();
    m_acc = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_in_ready", 64'(in_ready), 64'(1));
    check("t6_out_idle", 64'(out_valid), 64'(0));
    beat(fill(5), fill(-1), 1'b1, 1'b0, 4'd7, 1'b0, '0);
    beat(fill(2), fill(3), 1'b0, 1'b1, 4'd7, 1'b0, '0);
    drain();
    check("t6_frame_ok", 64'(frame_err), 64'(0));

    // start beat while a channel is still open
    beat(fill(1), fill(2), 1'b1, 1'b0, 4'd8, 1'b0, '0);
    beat(fill(1), fill(2), 1'b1, 1'b1, 4'd8, 1'b0, '0);
    drain();
    check("t7_start_open", 64'(frame_err), 64'(1));

    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
